// File: rtl/pong_game_engine.sv
// pong_game_engine: two-player pong physics, scoring, match flow and per-pixel RGB generation
module pong_game_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int TICK_Y       = 481,
  parameter int BORDER       = 5,
  parameter int PAD_H        = 90,
  parameter int PAD_W        = 4,
  parameter int PAD1_X       = 40,
  parameter int PAD2_X       = 600,
  parameter int PAD_SPEED    = 2,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up1,
  input  logic               down1,
  input  logic               up2,
  input  logic               down2,
  input  logic               start,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic [11:0]        rgb,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         game_state,
  output logic [1:0]         winner,
  output logic               border_on,
  output logic               pad1_on,
  output logic               pad2_on,
  output logic               ball_on
);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [9:0] BD     = 10'(BORDER);
  localparam logic [9:0] P_MAX  = 10'(V_ACTIVE - BORDER - PAD_H);
  localparam logic [9:0] P_INIT = 10'((V_ACTIVE - PAD_H) / 2);
  localparam logic [9:0] BX0    = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] BY0    = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] BS     = 10'(BALL_SIZE);
  localparam logic [9:0] BV     = 10'(BALL_SPEED);
  localparam logic [9:0] PV     = 10'(PAD_SPEED);
  localparam logic [9:0] PW     = 10'(PAD_W);
  localparam logic [9:0] PH     = 10'(PAD_H);
  localparam logic [9:0] P1X    = 10'(PAD1_X);
  localparam logic [9:0] P2X    = 10'(PAD2_X);
  localparam logic [9:0] R_LIM  = 10'(H_ACTIVE - 1 - BORDER);
  localparam logic [9:0] B_LIM  = 10'(V_ACTIVE - 1 - BORDER);
  localparam logic [CW-1:0] SF  = CW'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WS = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE = 2'b00, SERVE = 2'b01, PLAY = 2'b10, OVER = 2'b11} state_t;

  state_t state_q, state_d;
  logic [9:0] p1_q, p1_d, p2_q, p2_d, bx_q, bx_d, by_q, by_d;
  logic dx_q, dx_d, dy_q, dy_d, start_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0] win_q, win_d;
  logic [11:0] rgb_q, rgb_d;
  logic tick, start_rise, left_miss, right_miss, hit1, hit2, in_ball;
  logic [2:0] rx, ry;
  logic [7:0] mask_row;

  function automatic logic [9:0] pad_next(input logic [9:0] p, input logic up, input logic dn);
    pad_next = (up && !dn) ? ((p < BD + PV) ? BD : p - PV)
             : (dn && !up) ? ((p + PV > P_MAX) ? P_MAX : p + PV) : p;
  endfunction

  function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by, input logic [9:0] px, input logic [9:0] py);
    overlap = (bx + BS > px) && (bx < px + PW) && (by + BS > py) && (by < py + PH);
  endfunction

  function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] s);
    sat = (s == WS) ? s : s + SCORE_W'(1);
  endfunction

  assign tick       = (y == 10'(TICK_Y)) && (x == 10'd0);
  assign start_rise = start & ~start_q;
  assign left_miss  = bx_q <= BD;
  assign right_miss = bx_q + BS - 10'd1 >= R_LIM;
  assign hit1       = overlap(bx_q, by_q, P1X, p1_q);
  assign hit2       = overlap(bx_q, by_q, P2X, p2_q);

  assign rx        = 3'(x - bx_q);
  assign ry        = 3'(y - by_q);
  assign in_ball   = (x >= bx_q) && (x < bx_q + BS) && (y >= by_q) && (y < by_q + BS);
  assign mask_row  = (BALL_SIZE != 8) ? 8'hFF
                   : (ry == 3'd0 || ry == 3'd7) ? 8'h3C
                   : (ry == 3'd1 || ry == 3'd6) ? 8'h7E : 8'hFF;
  assign border_on = (x < BD) || (x >= 10'(H_ACTIVE - BORDER)) || (y < BD) || (y >= 10'(V_ACTIVE - BORDER));
  assign pad1_on   = (state_q != IDLE) && (x >= P1X) && (x < P1X + PW) && (y >= p1_q) && (y < p1_q + PH);
  assign pad2_on   = (state_q != IDLE) && (x >= P2X) && (x < P2X + PW) && (y >= p2_q) && (y < p2_q + PH);
  assign ball_on   = (state_q == SERVE || state_q == PLAY) && in_ball && mask_row[rx];

  assign rgb        = rgb_q;
  assign score1     = s1_q;
  assign score2     = s2_q;
  assign game_state = state_q;
  assign winner     = win_q;

  // next-state: match flow, per-frame physics and pixel colour
  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    rgb_d   = !video_on ? 12'h000 : border_on ? 12'hFF0 : pad1_on ? 12'h6A2
            : pad2_on ? 12'hA5C : ball_on ? 12'hF0F : 12'h000;
    if (state_q == IDLE) begin
      bx_d = BX0;
      by_d = BY0;
      if (start_rise) begin
        state_d = SERVE;
        cnt_d   = SF;
      end
    end else if (state_q == OVER) begin
      if (start_rise) begin
        state_d = IDLE;
        s1_d    = '0;
        s2_d    = '0;
        win_d   = 2'b00;
      end
    end else if (tick) begin
      p1_d = pad_next(p1_q, up1, down1);
      p2_d = pad_next(p2_q, up2, down2);
      if (state_q == SERVE) begin
        bx_d  = BX0;
        by_d  = BY0;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = PLAY;
      end else if (left_miss || right_miss) begin
        s2_d = left_miss ? sat(s2_q) : s2_q;
        s1_d = left_miss ? s1_q : sat(s1_q);
        if (left_miss ? (s2_d == WS) : (s1_d == WS)) begin
          state_d = OVER;
          win_d   = left_miss ? 2'b10 : 2'b01;
        end else begin
          state_d = SERVE;
          bx_d    = BX0;
          by_d    = BY0;
          dx_d    = ~left_miss;
          cnt_d   = SF;
        end
      end else begin
        dx_d = (!dx_q && hit1) ? 1'b1 : (dx_q && hit2) ? 1'b0 : dx_q;
        dy_d = (by_q <= BD) ? 1'b1 : (by_q + BS - 10'd1 >= B_LIM) ? 1'b0 : dy_q;
        bx_d = dx_d ? bx_q + BV : bx_q - BV;
        by_d = dy_d ? by_q + BV : by_q - BV;
      end
    end
  end

  // state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      p1_q    <= P_INIT;
      p2_q    <= P_INIT;
      bx_q    <= BX0;
      by_q    <= BY0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= 2'b00;
      rgb_q   <= 12'h000;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
      rgb_q   <= rgb_d;
      start_q <= start;
    end
  end
endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: directed pixel vectors plus hand-traced rally sequences for pong_game_engine
module tb_pong_game_engine;
  logic clk = 1'b0;
  logic reset, up1, down1, up2, down2, start, video_on;
  logic [9:0] x, y;
  logic [11:0] rgb;
  logic [3:0] score1, score2;
  logic [1:0] game_state, winner;
  logic border_on, pad1_on, pad2_on, ball_on;
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vid;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [22];

  always #5 clk = ~clk;

  pong_game_engine dut (
    .clk(clk), .reset(reset), .up1(up1), .down1(down1), .up2(up2), .down2(down2),
    .start(start), .video_on(video_on), .x(x), .y(y), .rgb(rgb),
    .score1(score1), .score2(score2), .game_state(game_state), .winner(winner),
    .border_on(border_on), .pad1_on(pad1_on), .pad2_on(pad2_on), .ball_on(ball_on)
  );

  function automatic vec_t mk(input int px, input int py, input logic v, input logic [11:0] c, input logic [3:0] h);
    vec_t r;
    r.x = 10'(px);
    r.y = 10'(py);
    r.vid = v;
    r.exp = {c, h};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int k);
    for (int i = 0; i < k; i++) begin
      x = 10'd0;
      y = 10'd481;
      cyc();
      x = 10'd100;
      y = 10'd100;
      cyc();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic sample(input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    @(negedge clk);
  endtask

  task automatic check_ball(input string name, input int bx, input int by);
    logic [3:0] got;
    sample(bx + 2, by);     got[3] = ball_on;
    sample(bx + 2, by - 1); got[2] = ball_on;
    sample(bx, by + 3);     got[1] = ball_on;
    sample(bx - 1, by + 3); got[0] = ball_on;
    chk(name, 32'(got), 32'hA);
  endtask

  task automatic check_pad(input string name, input bit second, input int top);
    logic [1:0] got;
    int px;
    px = second ? 600 : 40;
    sample(px, top);     got[1] = second ? pad2_on : pad1_on;
    sample(px, top - 1); got[0] = second ? pad2_on : pad1_on;
    chk(name, 32'(got), 32'h2);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] hits;
    tbl[0]  = mk(0,   0,   1'b1, 12'hFF0, 4'b1000);
    tbl[1]  = mk(100, 100, 1'b0, 12'h000, 4'b0000);
    tbl[2]  = mk(320, 240, 1'b0, 12'h000, 4'b0001);
    tbl[3]  = mk(40,  195, 1'b1, 12'h6A2, 4'b0100);
    tbl[4]  = mk(43,  284, 1'b1, 12'h6A2, 4'b0100);
    tbl[5]  = mk(44,  200, 1'b1, 12'h000, 4'b0000);
    tbl[6]  = mk(40,  194, 1'b1, 12'h000, 4'b0000);
    tbl[7]  = mk(40,  285, 1'b1, 12'h000, 4'b0000);
    tbl[8]  = mk(600, 195, 1'b1, 12'hA5C, 4'b0010);
    tbl[9]  = mk(603, 284, 1'b1, 12'hA5C, 4'b0010);
    tbl[10] = mk(318, 236, 1'b1, 12'hF0F, 4'b0001);
    tbl[11] = mk(316, 236, 1'b1, 12'h000, 4'b0000);
    tbl[12] = mk(316, 239, 1'b1, 12'hF0F, 4'b0001);
    tbl[13] = mk(323, 243, 1'b1, 12'h000, 4'b0000);
    tbl[14] = mk(320, 243, 1'b1, 12'hF0F, 4'b0001);
    tbl[15] = mk(639, 479, 1'b1, 12'hFF0, 4'b1000);
    tbl[16] = mk(635, 240, 1'b1, 12'hFF0, 4'b1000);
    tbl[17] = mk(634, 240, 1'b1, 12'h000, 4'b0000);
    tbl[18] = mk(4,   240, 1'b1, 12'hFF0, 4'b1000);
    tbl[19] = mk(5,   240, 1'b1, 12'h000, 4'b0000);
    tbl[20] = mk(320, 475, 1'b1, 12'hFF0, 4'b1000);
    tbl[21] = mk(320, 474, 1'b1, 12'h000, 4'b0000);

    reset = 1'b0; start = 1'b0; up1 = 1'b0; down1 = 1'b0; up2 = 1'b0; down2 = 1'b0;
    video_on = 1'b0; x = 10'd100; y = 10'd100;
    #13;
    chk("rst_held_state", 32'(game_state), 32'h0);
    chk("rst_held_rgb", 32'(rgb), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc();
    chk("idle_state", 32'(game_state), 32'h0);
    chk("idle_score1", 32'(score1), 32'h0);
    chk("idle_score2", 32'(score2), 32'h0);
    chk("idle_winner", 32'(winner), 32'h0);
    sample(320, 240);
    chk("idle_ball_hidden", 32'(ball_on), 32'h0);
    sample(40, 200);
    chk("idle_pad_hidden", 32'(pad1_on), 32'h0);
    cyc();
    x = 10'd0; y = 10'd0; video_on = 1'b1;
    cyc();
    chk("idle_rgb_00", 32'(rgb), 32'hFF0);

    pulse_start();
    chk("serve_state", 32'(game_state), 32'h1);
    check_ball("serve_ball_centre", 316, 236);
    check_pad("serve_pad1_init", 1'b0, 195);
    check_pad("serve_pad2_init", 1'b1, 195);

    cyc();
    for (int i = 0; i < 22; i++) begin
      x = tbl[i].x;
      y = tbl[i].y;
      video_on = tbl[i].vid;
      @(negedge clk);
      hits = {border_on, pad1_on, pad2_on, ball_on};
      cyc();
      chk($sformatf("pix%0d", i), 32'({rgb, hits}), 32'(tbl[i].exp));
    end

    up1 = 1'b1; down2 = 1'b1;
    tick_n(59);
    chk("serve_59_ticks", 32'(game_state), 32'h1);
    tick_n(1);
    chk("play_after_60", 32'(game_state), 32'h2);
    check_pad("pad1_after_serve", 1'b0, 75);
    check_pad("pad2_after_serve", 1'b1, 315);
    check_ball("play_n0", 316, 236);
    tick_n(40);
    check_ball("play_n40", 396, 316);
    check_pad("pad1_clamp_top", 1'b0, 5);
    check_pad("pad2_clamp_bottom", 1'b1, 385);
    tick_n(76);
    check_ball("play_n116_bottom", 548, 468);
    tick_n(1);
    check_ball("play_n117_dir_y_up", 550, 466);
    tick_n(22);
    check_ball("play_n139_at_pad2", 594, 422);
    tick_n(1);
    check_ball("play_n140_dir_x_left", 592, 420);
    chk("pad2_bounce_score1", 32'(score1), 32'h0);
    chk("pad2_bounce_state", 32'(game_state), 32'h2);
    tick_n(294);
    check_ball("play_left_edge", 4, 176);
    tick_n(1);
    chk("left_miss_score2", 32'(score2), 32'h1);
    chk("left_miss_score1", 32'(score1), 32'h0);
    chk("left_miss_state", 32'(game_state), 32'h1);
    check_ball("left_miss_recentre", 316, 236);
    tick_n(61);
    chk("second_rally_state", 32'(game_state), 32'h2);
    check_ball("second_rally_dir_x_left", 314, 238);

    cyc();
    x = 10'd0; y = 10'd0; video_on = 1'b1;
    cyc();
    cyc();
    chk("pre_reset_rgb", 32'(rgb), 32'hFF0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async_rst_state", 32'(game_state), 32'h0);
    chk("async_rst_score2", 32'(score2), 32'h0);
    chk("async_rst_rgb", 32'(rgb), 32'h0);
    chk("async_rst_winner", 32'(winner), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    up1 = 1'b0; down2 = 1'b0;
    cyc();

    pulse_start();
    check_pad("rst_pad1_top", 1'b0, 195);
    check_pad("rst_pad2_top", 1'b1, 195);
    for (int r = 1; r <= 9; r++) begin
      up2 = r[0];
      down2 = ~r[0];
      tick_n(60 + 157);
      chk($sformatf("rally%0d_score1", r), 32'(score1), 32'(r));
      if (r < 9) chk($sformatf("rally%0d_state", r), 32'(game_state), 32'h1);
    end
    chk("win_state", 32'(game_state), 32'h3);
    chk("win_winner", 32'(winner), 32'h1);
    chk("win_score2", 32'(score2), 32'h0);
    up2 = 1'b0; down2 = 1'b1;
    tick_n(5);
    chk("over_frozen_state", 32'(game_state), 32'h3);
    chk("over_frozen_score1", 32'(score1), 32'h9);
    chk("over_frozen_winner", 32'(winner), 32'h1);
    check_pad("over_pad2_frozen", 1'b1, 5);
    down2 = 1'b0;
    pulse_start();
    chk("restart_state", 32'(game_state), 32'h0);
    chk("restart_score1", 32'(score1), 32'h0);
    chk("restart_winner", 32'(winner), 32'h0);

    pulse_start();
    up1 = 1'b1; down1 = 1'b1;
    tick_n(3);
    check_pad("both_buttons_hold", 1'b0, 195);
    chk("both_buttons_state", 32'(game_state), 32'h1);
    up1 = 1'b0; down1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
